// File: rtl/ps2_code_sequencer.sv
// Frames raw PS/2 bytes (E0/F0 prefixed sequences) into 16-bit codes with a one-cycle status strobe.
// Define PS2_SEQ_MAKE_CODES_EN to emit make codes as well as break codes.
module ps2_code_sequencer #(
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        byte_err,
   output logic [15:0] code,
   output logic        ext,
   output logic        status,
   output logic        busy,
   output logic [7:0]  err_cnt
);

`ifdef PS2_SEQ_MAKE_CODES_EN
   localparam bit MAKE_EN = 1'b1;
`else
   localparam bit MAKE_EN = 1'b0;
`endif

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } state_t;

   state_t      state_q;
   logic [15:0] timer_q;
   logic [15:0] code_q;
   logic        ext_q;
   logic        status_q;
   logic [7:0]  err_cnt_q;

   logic       is_e0;
   logic       is_f0;
   logic       abort_byte;
   logic [7:0] err_cnt_d;

   assign is_e0      = (byte_in == 8'hE0);
   assign is_f0      = (byte_in == 8'hF0);
   // Receiver errors and keyboard overrun/fill bytes abort regardless of state.
   assign abort_byte = byte_err || (byte_in == 8'h00) || (byte_in == 8'hFF);
   assign err_cnt_d  = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

   // NOTE: the asynchronous reset clears every register, including the
   // held code, so a partial sequence never survives reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         code_q    <= '0;
         ext_q     <= 1'b0;
         status_q  <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking defaults here are overridden by later
         // assignments in the same block; the last one wins.
         status_q <= 1'b0;
         if (byte_valid) begin
            timer_q <= '0;
            if (abort_byte) begin
               state_q   <= IDLE;
               err_cnt_q <= err_cnt_d;
            end else begin
               unique case (state_q)
                  IDLE: begin
                     if (is_e0) begin
                        state_q <= EXT;
                     end else if (is_f0) begin
                        state_q <= BRK;
                     end else if (MAKE_EN) begin
                        code_q   <= {8'h00, byte_in};
                        ext_q    <= 1'b0;
                        status_q <= 1'b1;
                     end
                  end
                  EXT: begin
                     if (is_f0) begin
                        state_q <= EXT_BRK;
                     end else if (is_e0) begin
                        state_q <= EXT;
                     end else begin
                        state_q <= IDLE;
                        if (MAKE_EN) begin
                           code_q   <= {8'h00, byte_in};
                           ext_q    <= 1'b1;
                           status_q <= 1'b1;
                        end
                     end
                  end
                  BRK: begin
                     if (is_e0) begin
                        state_q   <= EXT;
                        err_cnt_q <= err_cnt_d;
                     end else if (is_f0) begin
                        state_q <= BRK;
                     end else begin
                        state_q  <= IDLE;
                        code_q   <= {8'hF0, byte_in};
                        ext_q    <= 1'b0;
                        status_q <= 1'b1;
                     end
                  end
                  EXT_BRK: begin
                     state_q <= IDLE;
                     if (is_e0 || is_f0) begin
                        err_cnt_q <= err_cnt_d;
                     end else begin
                        code_q   <= {8'hF0, byte_in};
                        ext_q    <= 1'b1;
                        status_q <= 1'b1;
                     end
                  end
                  default: state_q <= IDLE;
               endcase
            end
         end else if (state_q != IDLE) begin
            // A byte arriving in the expiry cycle takes the branch above instead.
            if (timer_q == TIMER_LAST) begin
               state_q   <= IDLE;
               timer_q   <= '0;
               err_cnt_q <= err_cnt_d;
            end else begin
               timer_q <= timer_q + 16'd1;
            end
         end
      end
   end

   assign code    = code_q;
   assign ext     = ext_q;
   assign status  = status_q;
   assign busy    = (state_q != IDLE);
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ps2_code_sequencer.sv
// Directed self-checking bench for ps2_code_sequencer (TIMEOUT=8); follows PS2_SEQ_MAKE_CODES_EN.
module tb_ps2_code_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_err;
   logic [15:0] code;
   logic        ext;
   logic        status;
   logic        busy;
   logic [7:0]  err_cnt;

   int tests = 0;
   int fails = 0;
   int exp_err = 0;
   logic [15:0] exp_code;
   logic        exp_ext;

`ifdef PS2_SEQ_MAKE_CODES_EN
   localparam bit MAKE_EN = 1'b1;
`else
   localparam bit MAKE_EN = 1'b0;
`endif

   ps2_code_sequencer #(.TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_err   (byte_err),
      .code       (code),
      .ext        (ext),
      .status     (status),
      .busy       (busy),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one cycle of input, then return 1 time unit after the sampling edge.
   task automatic drive(input logic [7:0] b, input logic v, input logic e);
      byte_in    = b;
      byte_valid = v;
      byte_err   = e;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      drive(b, 1'b1, 1'b0);
   endtask

   task automatic idle();
      drive(8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      byte_in = 8'h00;
      byte_valid = 1'b0;
      byte_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_code", 32'(code), 32'h0000);
      check("rst_ext", 32'(ext), 32'h0);
      check("rst_status", 32'(status), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(err_cnt), 32'h0);
      rst = 1'b0;
      idle();

      // Break code F0 16
      send(8'hF0);
      check("brk_busy", 32'(busy), 32'h1);
      check("brk_status_mid", 32'(status), 32'h0);
      send(8'h16);
      check("brk_status", 32'(status), 32'h1);
      check("brk_code", 32'(code), 32'hF016);
      check("brk_ext", 32'(ext), 32'h0);
      check("brk_busy_done", 32'(busy), 32'h0);
      idle();
      check("brk_status_1cyc", 32'(status), 32'h0);
      check("brk_code_held", 32'(code), 32'hF016);

      // Extended break E0 F0 75
      send(8'hE0);
      send(8'hF0);
      check("xbrk_busy", 32'(busy), 32'h1);
      send(8'h75);
      check("xbrk_code", 32'(code), 32'hF075);
      check("xbrk_ext", 32'(ext), 32'h1);
      check("xbrk_status", 32'(status), 32'h1);
      exp_code = 16'hF075;
      exp_ext  = 1'b1;
      idle();

      // Extended make E0 75
      send(8'hE0);
      send(8'h75);
      if (MAKE_EN) begin
         exp_code = 16'h0075;
         exp_ext  = 1'b1;
      end
      check("make_status", 32'(status), 32'(MAKE_EN));
      check("make_code", 32'(code), 32'(exp_code));
      check("make_ext", 32'(ext), 32'(exp_ext));
      check("make_busy", 32'(busy), 32'h0);
      idle();

      // Timeout: F0 then idle; abort on the 8th idle cycle
      send(8'hF0);
      repeat (7) idle();
      check("to_busy_before", 32'(busy), 32'h1);
      check("to_err_before", 32'(err_cnt), 32'(exp_err));
      idle();
      exp_err++;
      check("to_busy_after", 32'(busy), 32'h0);
      check("to_err_after", 32'(err_cnt), 32'(exp_err));
      check("to_no_status", 32'(status), 32'h0);
      send(8'h45);
      if (MAKE_EN) begin
         exp_code = 16'h0045;
         exp_ext  = 1'b0;
      end
      check("to_next_status", 32'(status), 32'(MAKE_EN));
      check("to_next_code", 32'(code), 32'(exp_code));
      check("to_next_ext", 32'(ext), 32'(exp_ext));
      check("to_next_busy", 32'(busy), 32'h0);
      idle();

      // Byte in the expiry cycle beats the timeout
      send(8'hF0);
      repeat (7) idle();
      send(8'h16);
      exp_code = 16'hF016;
      exp_ext  = 1'b0;
      check("exp_byte_status", 32'(status), 32'h1);
      check("exp_byte_code", 32'(code), 32'(exp_code));
      check("exp_byte_err", 32'(err_cnt), 32'(exp_err));
      idle();

      // Receiver error on data byte after F0
      send(8'hF0);
      drive(8'h1E, 1'b1, 1'b1);
      exp_err++;
      check("rxerr_status", 32'(status), 32'h0);
      check("rxerr_busy", 32'(busy), 32'h0);
      check("rxerr_err", 32'(err_cnt), 32'(exp_err));
      check("rxerr_code", 32'(code), 32'(exp_code));
      drive(8'h1E, 1'b0, 1'b1);
      check("rxerr_novalid", 32'(err_cnt), 32'(exp_err));

      // FF in IDLE
      send(8'hFF);
      exp_err++;
      check("ff_err", 32'(err_cnt), 32'(exp_err));
      check("ff_status", 32'(status), 32'h0);

      // E0 after F0 counts an error and moves to EXT
      send(8'hF0);
      send(8'hE0);
      exp_err++;
      check("brk_e0_err", 32'(err_cnt), 32'(exp_err));
      check("brk_e0_busy", 32'(busy), 32'h1);
      send(8'h75);
      if (MAKE_EN) begin
         exp_code = 16'h0075;
         exp_ext  = 1'b1;
      end
      check("brk_e0_status", 32'(status), 32'(MAKE_EN));
      check("brk_e0_code", 32'(code), 32'(exp_code));
      check("brk_e0_ext", 32'(ext), 32'(exp_ext));
      check("brk_e0_idle", 32'(busy), 32'h0);

      // Prefix after E0 F0 aborts
      send(8'hE0);
      send(8'hF0);
      send(8'hF0);
      exp_err++;
      check("xbrk_f0_err", 32'(err_cnt), 32'(exp_err));
      check("xbrk_f0_busy", 32'(busy), 32'h0);

      // Saturation
      for (int i = 0; i < 260; i++) send(8'hFF);
      check("sat_err", 32'(err_cnt), 32'hFF);
      check("sat_busy", 32'(busy), 32'h0);
      idle();

      // Asynchronous reset mid-sequence
      send(8'hE0);
      send(8'hF0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_code", 32'(code), 32'h0000);
      check("arst_ext", 32'(ext), 32'h0);
      check("arst_status", 32'(status), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_err", 32'(err_cnt), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(8'hF0);
      send(8'h45);
      check("post_rst_code", 32'(code), 32'hF045);
      check("post_rst_ext", 32'(ext), 32'h0);
      check("post_rst_status", 32'(status), 32'h1);
      check("post_rst_err", 32'(err_cnt), 32'h0);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
